// File: rtl/snn_pkg.sv
// Shared SNN constants: SRAM geometry, requester IDs and burst sizing.
package snn_pkg;

    localparam int SNN_ADDR_W      = 10;
    localparam int SNN_DATA_W      = 32;

    localparam int REQ_HOST        = 0;
    localparam int REQ_SPKGEN      = 1;
    localparam int REQ_WFETCH      = 2;

    localparam int NUM_OUT_NEURONS = 10;

    function automatic int snn_wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/snn_rr_picker.sv
// Combinational round-robin select: first set request at or above ptr_i, wrapping to 0.
module snn_rr_picker
    import snn_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             vld_o
);

    logic [PTR_W:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N)) begin
                cand = cand - (PTR_W+1)'(N);
            end
            if (!vld_o && req_i[cand[PTR_W-1:0]]) begin
                gnt_o[cand[PTR_W-1:0]] = 1'b1;
                idx_o                  = cand[PTR_W-1:0];
                vld_o                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snn_mem_arbiter.sv
// Round-robin SRAM arbiter with bounded burst lock and tagged read return.
// Optional per-requester grant/wait counters when SNN_ARB_PERF_EN is defined.
module snn_mem_arbiter
    import snn_pkg::*;
#(
    parameter int ADDR_W     = SNN_ADDR_W,
    parameter int DATA_W     = SNN_DATA_W,
    parameter int NUM_REQ    = 3,
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef SNN_ARB_PERF_EN
    input  logic                       perf_clr_i,
    output logic [NUM_REQ*16-1:0]      perf_gnt_o,
    output logic [NUM_REQ*16-1:0]      perf_wait_o,
`endif
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         lock_i,
    input  logic [NUM_REQ-1:0]         we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       mem_cs_o,
    output logic                       mem_we_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    input  logic [DATA_W-1:0]          mem_rdata_i
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               lock_vld_q, lock_vld_d;
    logic [PTR_W-1:0]   lock_own_q, lock_own_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [CNT_W-1:0]   cnt_inc;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               owner_active;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_vld;

    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    logic               mem_cs_q, mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [NUM_REQ-1:0] cmd_tag_q;
    logic [NUM_REQ-1:0] tag_q [RD_LATENCY];

    snn_rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    // A lock owner that still requests bypasses the round-robin search entirely.
    assign owner_active = lock_vld_q && req_i[lock_own_q];

    always_comb begin
        gnt     = pick_gnt;
        gnt_idx = pick_idx;
        gnt_vld = pick_vld;
        if (owner_active) begin
            gnt             = '0;
            gnt[lock_own_q] = 1'b1;
            gnt_idx         = lock_own_q;
            gnt_vld         = 1'b1;
        end
    end

    assign gnt_o = rst ? '0 : gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                sel_we    = we_i[k];
                sel_addr  = addr_i[k*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_vld_d = lock_vld_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        cnt_inc    = owner_active ? lock_cnt_q + 1'b1 : CNT_W'(1);
        if (lock_vld_q && !owner_active) begin
            lock_vld_d = 1'b0;
            lock_cnt_d = '0;
        end
        if (gnt_vld) begin
            ptr_d = PTR_W'(snn_wrap_inc(int'(gnt_idx), NUM_REQ));
            if (lock_i[gnt_idx] && (cnt_inc < CNT_W'(LOCK_MAX))) begin
                lock_vld_d = 1'b1;
                lock_own_d = gnt_idx;
                lock_cnt_d = cnt_inc;
            end else begin
                lock_vld_d = 1'b0;
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            lock_vld_q  <= 1'b0;
            lock_own_q  <= '0;
            lock_cnt_q  <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cmd_tag_q   <= '0;
            tag_q[0]    <= '0;
            rdata_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
            mem_cs_q   <= gnt_vld;
            mem_we_q   <= gnt_vld && sel_we;
            if (gnt_vld) begin
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_wdata;
            end
            cmd_tag_q <= (gnt_vld && !sel_we) ? gnt : '0;
            tag_q[0]  <= cmd_tag_q;
            if (|tag_q[RD_LATENCY-1]) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    // Remaining tag stages line the requester ID up with the SRAM data.
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_tag
        always_ff @(posedge clk) begin
            if (rst) begin
                tag_q[gi] <= '0;
            end else begin
                tag_q[gi] <= tag_q[gi-1];
            end
        end
    end

    assign mem_cs_o    = mem_cs_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign rvalid_o    = tag_q[RD_LATENCY-1];
    assign rdata_o     = (|rvalid_o) ? mem_rdata_i : rdata_q;

`ifdef SNN_ARB_PERF_EN
    logic [15:0] perf_gnt_q  [NUM_REQ];
    logic [15:0] perf_wait_q [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        always_ff @(posedge clk) begin
            if (rst || perf_clr_i) begin
                perf_gnt_q[gi]  <= '0;
                perf_wait_q[gi] <= '0;
            end else begin
                if (gnt[gi] && (perf_gnt_q[gi] != 16'hFFFF)) begin
                    perf_gnt_q[gi] <= perf_gnt_q[gi] + 16'd1;
                end
                if (req_i[gi] && !gnt[gi] && (perf_wait_q[gi] != 16'hFFFF)) begin
                    perf_wait_q[gi] <= perf_wait_q[gi] + 16'd1;
                end
            end
        end
        assign perf_gnt_o[gi*16 +: 16]  = perf_gnt_q[gi];
        assign perf_wait_o[gi*16 +: 16] = perf_wait_q[gi];
    end
`endif

endmodule

// File: tb/tb_snn_mem_arbiter.sv
// Directed bench for snn_mem_arbiter: vector table plus lock, reset and perf sequences.
module tb_snn_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, lock, we;
    logic [29:0] addr;
    logic [95:0] wdata;
    logic [2:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        mem_cs, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef SNN_ARB_PERF_EN
    logic        perf_clr;
    logic [47:0] perf_gnt, perf_wait;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    snn_mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
`ifdef SNN_ARB_PERF_EN
        .perf_clr_i  (perf_clr),
        .perf_gnt_o  (perf_gnt),
        .perf_wait_o (perf_wait),
`endif
        .req_i       (req),
        .lock_i      (lock),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .mem_cs_o    (mem_cs),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // SRAM model, one-cycle registered read; word a preloaded with 0xC0DE0000 | a.
    logic [31:0] mem [1024];
    logic [31:0] rd_q;
    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 32'hC0DE_0000 | a;
        rd_q = '0;
    end
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rd_q <= mem[mem_addr];
        end
    end
    assign mem_rdata = rd_q;

    typedef struct {
        logic [2:0]  req, lock, we;
        logic [29:0] addr;
        logic [95:0] wdata;
        logic [2:0]  gnt, rvalid;
        logic        cs, mwe, chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] l, input logic [2:0] w,
                         input logic [29:0] a, input logic [95:0] d);
        @(posedge clk);
        #1;
        req = r; lock = l; we = w; addr = a; wdata = d;
        @(negedge clk);
    endtask

    localparam logic [29:0] A_T1 = {10'h030, 10'h020, 10'h010};

    initial begin
        vecs[0]  = '{3'b111, 3'b000, 3'b000, A_T1, 96'h0, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{3'b111, 3'b000, 3'b000, A_T1, 96'h0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{3'b111, 3'b000, 3'b000, A_T1, 96'h0, 3'b100, 3'b001, 1'b1, 1'b0, 1'b1, 32'hC0DE_0010};
        vecs[3]  = '{3'b111, 3'b000, 3'b000, A_T1, 96'h0, 3'b001, 3'b010, 1'b1, 1'b0, 1'b1, 32'hC0DE_0020};
        vecs[4]  = '{3'b000, 3'b000, 3'b000, A_T1, 96'h0, 3'b000, 3'b100, 1'b1, 1'b0, 1'b1, 32'hC0DE_0030};
        vecs[5]  = '{3'b000, 3'b000, 3'b000, A_T1, 96'h0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b1, 32'hC0DE_0010};
        vecs[6]  = '{3'b001, 3'b000, 3'b001, {20'h0, 10'h3FF}, {64'h0, 32'hDEAD_BEEF},
                     3'b001, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{3'b010, 3'b000, 3'b000, {10'h0, 10'h3FF, 10'h0}, 96'h0,
                     3'b010, 3'b000, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[8]  = '{3'b000, 3'b000, 3'b000, 30'h0, 96'h0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{3'b000, 3'b000, 3'b000, 30'h0, 96'h0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[10] = '{3'b000, 3'b000, 3'b000, 30'h0, 96'h0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};

        rst = 1'b1; req = 3'b111; lock = '0; we = '0; addr = '0; wdata = '0;
`ifdef SNN_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("gnt_in_reset", 96'(gnt), 96'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = '0;
        @(negedge clk);
        chk("rst_gnt", 96'(gnt), 96'h0);
        chk("rst_rvalid", 96'(rvalid), 96'h0);
        chk("rst_cs", 96'(mem_cs), 96'h0);
        chk("rst_we", 96'(mem_we), 96'h0);
        chk("rst_addr", 96'(mem_addr), 96'h0);
        chk("rst_wdata", 96'(mem_wdata), 96'h0);
        chk("rst_rdata", 96'(rdata), 96'h0);
        $display("reset: gnt=%b rvalid=%b cs=%b", gnt, rvalid, mem_cs);

        // Round-robin order, read return, write-then-read through 0x3FF.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].req, vecs[i].lock, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            $display("vec %0d: req=%b gnt=%b rvalid=%b cs=%b we=%b rdata=%h",
                     i, req, gnt, rvalid, mem_cs, mem_we, rdata);
            chk($sformatf("vec%0d_gnt", i), 96'(gnt), 96'(vecs[i].gnt));
            chk($sformatf("vec%0d_rvalid", i), 96'(rvalid), 96'(vecs[i].rvalid));
            chk($sformatf("vec%0d_cs", i), 96'(mem_cs), 96'(vecs[i].cs));
            chk($sformatf("vec%0d_we", i), 96'(mem_we), 96'(vecs[i].mwe));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), 96'(rdata), 96'(vecs[i].rd));
        end

        // Weight-fetch burst of 10 locked reads while the host waits (pointer sits at 2).
        for (int j = 0; j < 13; j++) begin
            logic [2:0]  eg, ev;
            logic [31:0] ed;
            if (j < 10)       drive(3'b101, 3'b100, 3'b000, {10'(10'h100 + j), 10'h0, 10'h050}, 96'h0);
            else if (j == 10) drive(3'b001, 3'b000, 3'b000, {20'h0, 10'h050}, 96'h0);
            else              drive(3'b000, 3'b000, 3'b000, 30'h0, 96'h0);
            eg = (j < 10) ? 3'b100 : (j == 10) ? 3'b001 : 3'b000;
            ev = (j >= 2 && j < 12) ? 3'b100 : (j == 12) ? 3'b001 : 3'b000;
            ed = (j == 12) ? 32'hC0DE_0050 : 32'hC0DE_0100 + 32'(j - 2);
            $display("burst %0d: gnt=%b rvalid=%b rdata=%h", j, gnt, rvalid, rdata);
            chk($sformatf("burst%0d_gnt", j), 96'(gnt), 96'(eg));
            chk($sformatf("burst%0d_rvalid", j), 96'(rvalid), 96'(ev));
            if (j >= 2) chk($sformatf("burst%0d_rdata", j), 96'(rdata), 96'(ed));
        end

        // Lock bounded at 16 grants; waiting spike generator gets the next cycle.
        for (int j = 0; j < 17; j++) begin
            logic [2:0] eg;
            drive((j == 0) ? 3'b100 : 3'b110, 3'b100, 3'b000, {10'h200, 10'h060, 10'h0}, 96'h0);
            eg = (j < 16) ? 3'b100 : 3'b010;
            $display("lockmax %0d: gnt=%b", j, gnt);
            chk($sformatf("lockmax%0d_gnt", j), 96'(gnt), 96'(eg));
            if (j == 1) chk("lockmax_addr", 96'(mem_addr), 96'h200);
        end
        repeat (3) drive(3'b000, 3'b000, 3'b000, 30'h0, 96'h0);

        // Reset one cycle after a read grant drops the read and the pointer.
        drive(3'b001, 3'b000, 3'b000, {20'h0, 10'h010}, 96'h0);
        chk("rstmid_gnt", 96'(gnt), 96'h1);
        @(posedge clk);
        #1;
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("rstmid_cs_inflight", 96'(mem_cs), 96'h1);
        chk("rstmid_gnt_in_rst", 96'(gnt), 96'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = 3'b111; addr = A_T1;
        @(negedge clk);
        $display("rstmid: gnt=%b rvalid=%b cs=%b rdata=%h", gnt, rvalid, mem_cs, rdata);
        chk("rstmid_rvalid", 96'(rvalid), 96'h0);
        chk("rstmid_cs", 96'(mem_cs), 96'h0);
        chk("rstmid_rdata", 96'(rdata), 96'h0);
        chk("rstmid_ptr", 96'(gnt), 96'h1);
        drive(3'b000, 3'b000, 3'b000, 30'h0, 96'h0);
        chk("rstmid_rvalid2", 96'(rvalid), 96'h0);
        chk("rstmid_cs2", 96'(mem_cs), 96'h1);
        drive(3'b000, 3'b000, 3'b000, 30'h0, 96'h0);
        chk("rstmid_rvalid3", 96'(rvalid), 96'h1);
        chk("rstmid_rdata3", 96'(rdata), 96'hC0DE_0010);

`ifdef SNN_ARB_PERF_EN
        perf_clr = 1'b1;
        drive(3'b000, 3'b000, 3'b000, 30'h0, 96'h0);
        perf_clr = 1'b0;
        drive(3'b100, 3'b100, 3'b000, 30'h0, 96'h0);
        for (int j = 0; j < 5; j++) drive(3'b110, 3'b100, 3'b000, 30'h0, 96'h0);
        drive(3'b010, 3'b000, 3'b000, 30'h0, 96'h0);
        chk("perf_last_gnt", 96'(gnt), 96'h2);
        drive(3'b000, 3'b000, 3'b000, 30'h0, 96'h0);
        $display("perf: wait1=%0d gnt2=%0d gnt1=%0d", perf_wait[31:16], perf_gnt[47:32], perf_gnt[31:16]);
        chk("perf_wait1", 96'(perf_wait[31:16]), 96'd5);
        chk("perf_gnt2", 96'(perf_gnt[47:32]), 96'd6);
        chk("perf_gnt1", 96'(perf_gnt[31:16]), 96'd1);
        perf_clr = 1'b1;
        drive(3'b000, 3'b000, 3'b000, 30'h0, 96'h0);
        perf_clr = 1'b0;
        drive(3'b000, 3'b000, 3'b000, 30'h0, 96'h0);
        chk("perf_clr_gnt", 96'(perf_gnt), 96'h0);
        chk("perf_clr_wait", 96'(perf_wait), 96'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
